imem_boot_sequencer: RTL
========================

Name: imem_boot_sequencer

Overview:
- Boot controller for the 8-bit RISC-V pipeline. Owns the instruction-memory write port and the core reset.
- Sequence: optionally clears instruction memory, then loads a program from a host stream (valid/ready). It then holds the core in reset for a fixed interval and releases it into run mode (memory read).
- Replaces hand-driven address/instruction/rw/reset stimulus with one sequenced, checkable block.

Parameters:
- ADDR_W, 10: instruction-memory address width.
- DATA_W, 32: instruction width.
- IMEM_DEPTH, 1024: valid word count. Any address >= IMEM_DEPTH is out of range.
- RESET_HOLD, 4: core-reset hold cycles after load completes, before release. Must be >= 1.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low block reset.
- start  in  1  one-cycle request to begin a boot session. Sampled only in IDLE or RUN.
- clear_en  in  1  sampled with start. 1 = zero the whole memory before loading.
- host_valid  in  1  host word available.
- host_ready  out  1  sequencer accepts a word this cycle.
- host_addr  in  ADDR_W  target word address.
- host_data  in  DATA_W  instruction word.
- host_last  in  1  marks the final word of the program.
- imem_rw  out  1  0 = write mode, 1 = read/run mode.
- imem_wr_en  out  1  write strobe. Valid only when imem_rw=0.
- imem_addr  out  ADDR_W  write address (drives the memory's PC_write input).
- imem_wdata  out  DATA_W  write data (drives instruction_in).
- imem_reset  out  1  active-high instruction-memory reset (drives reset_IF_memory).
- core_reset  out  1  active-high pipeline reset (drives TOP reset).
- busy  out  1  session in progress (states IMRST..HOLD).
- done  out  1  high in RUN.
- load_count  out  ADDR_W+1  words written in LOAD this session.
- err  out  1  sticky: at least one out-of-range word was dropped this session.

Behaviour:
- All outputs are registered.
- Async reset (reset=0) values: state IDLE, core_reset=1, imem_rw=1, imem_reset=0, imem_wr_en=0, imem_addr=0, imem_wdata=0, host_ready=0, busy=0, done=0, load_count=0, err=0.
- Reset mid-session aborts immediately to these values. Memory contents are undefined afterwards.
- States:
  - IDLE: core_reset=1. start=1 -> IMRST; clear_en is latched, load_count and err are cleared.
  - IMRST (1 cycle): imem_reset=1, imem_rw=0. Next state is CLEAR if the latched clear_en=1, else LOAD.
  - CLEAR:
    - imem_rw=0, imem_wr_en=1, imem_wdata=0.
    - imem_addr steps 0..IMEM_DEPTH-1, one word per cycle.
    - The cycle after address IMEM_DEPTH-1 is written -> LOAD.
    - host_ready=0 throughout.
  - LOAD:
    - imem_rw=0, host_ready=1. A transfer happens when host_valid & host_ready.
    - In-range transfer: the next cycle has imem_wr_en=1 with imem_addr/imem_wdata equal to the accepted values (1-cycle latency), and load_count increments. Otherwise imem_wr_en=0.
    - Out-of-range transfer (host_addr >= IMEM_DEPTH): word dropped, no write, err<=1, load_count unchanged.
    - A transfer with host_last=1 -> HOLD, whether or not the word was dropped. host_ready goes 0 the cycle after the last transfer.
    - load_count saturates at 2^ADDR_W.
  - HOLD:
    - Entry cycle completes the pending last write, so imem_rw stays 0 that cycle.
    - Then imem_rw=1 and core_reset=1 for RESET_HOLD cycles, counted from the first cycle with imem_rw=1 -> RUN.
  - RUN: imem_rw=1, core_reset=0, done=1. start=1 -> IMRST (new session; core_reset reasserts the same cycle IMRST is entered).
- start is ignored in IMRST, CLEAR, LOAD and HOLD.
- host_valid outside LOAD is ignored; host_ready=0 there.
- A duplicate address in LOAD is written again; the last write wins. load_count counts both writes.
- core_reset=1 in every state except RUN.
- imem_wr_en=1 only in CLEAR, and in LOAD/HOLD-entry write cycles.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then release -> core_reset=1, imem_rw=1, host_ready=0, done=0, all counters 0.
- Load without clear:
  - start, clear_en=0. Host sends (1,0x00500083), (2,0x00600103), (3,0x00008183, last); host_valid held, no gaps.
  - -> three writes, each 1 cycle after acceptance, at addresses 1,2,3. load_count=3.
  - After the third write, imem_rw rises and core_reset stays 1 for exactly 4 cycles; then done=1 and core_reset=0.
- Clear then load, IMEM_DEPTH=16:
  - start, clear_en=1 -> imem_reset pulses 1 cycle, then 16 zero writes at addresses 0..15.
  - host_ready first rises the cycle after the address-15 write.
  - One word (7,0x003171B3, last) is then written; load_count=1.
- Backpressure and bounds, IMEM_DEPTH=16:
  - host_valid toggles every other cycle -> only handshaked words are written.
  - Word at addr 20 -> no write, err=1, load_count unchanged.
  - Last word addr 21 -> dropped, still enters HOLD.
- Restart and ignore:
  - start during LOAD -> no effect.
  - start in RUN -> core_reset=1 in the IMRST cycle; load_count and err are cleared.
- Mid-load reset: reset=0 asynchronously during LOAD -> all outputs take reset values without a clock edge; no further writes after release until start.

Source files
------------

// File: rtl/imem_boot_sequencer.sv
// Boot sequencer for the instruction memory: optional clear, host program load,
// timed core-reset hold, then release of the core into run mode.
module imem_boot_sequencer #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned RESET_HOLD = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_en,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              imem_rw,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              imem_reset,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   load_count,
    output logic              err
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

    localparam logic [CNT_W-1:0]  COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]  DEPTH_LIM = CNT_W'(IMEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(RESET_HOLD);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_IMRST = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_RUN   = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              clear_sel;
    logic              clear_sel_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;

    logic              host_ready_nxt;
    logic              imem_rw_nxt;
    logic              imem_wr_en_nxt;
    logic [ADDR_W-1:0] imem_addr_nxt;
    logic [DATA_W-1:0] imem_wdata_nxt;
    logic              imem_reset_nxt;
    logic              core_reset_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic [CNT_W-1:0]  load_count_nxt;
    logic              err_nxt;

    logic              in_range;
    logic              xfer;

    assign in_range = {1'b0, host_addr} < DEPTH_LIM;
    assign xfer     = host_ready && host_valid;

    // State and output registers; every output reflects the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            clear_sel  <= 1'b0;
            hold_cnt   <= '0;
            host_ready <= 1'b0;
            imem_rw    <= 1'b1;
            imem_wr_en <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            imem_reset <= 1'b0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_count <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            clear_sel  <= clear_sel_nxt;
            hold_cnt   <= hold_cnt_nxt;
            host_ready <= host_ready_nxt;
            imem_rw    <= imem_rw_nxt;
            imem_wr_en <= imem_wr_en_nxt;
            imem_addr  <= imem_addr_nxt;
            imem_wdata <= imem_wdata_nxt;
            imem_reset <= imem_reset_nxt;
            core_reset <= core_reset_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            load_count <= load_count_nxt;
            err        <= err_nxt;
        end
    end

    // Next-state, datapath updates, then output decode from the next state.
    always_comb begin
        state_nxt      = state;
        clear_sel_nxt  = clear_sel;
        hold_cnt_nxt   = hold_cnt;
        host_ready_nxt = 1'b0;
        imem_rw_nxt    = 1'b1;
        imem_wr_en_nxt = 1'b0;
        imem_addr_nxt  = imem_addr;
        imem_wdata_nxt = imem_wdata;
        imem_reset_nxt = 1'b0;
        core_reset_nxt = 1'b1;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        load_count_nxt = load_count;
        err_nxt        = err;

        case (state)
            S_IDLE, S_RUN: begin
                if (start) begin
                    state_nxt      = S_IMRST;
                    clear_sel_nxt  = clear_en;
                    load_count_nxt = '0;
                    err_nxt        = 1'b0;
                end
            end
            S_IMRST: begin
                if (clear_sel) begin
                    state_nxt     = S_CLEAR;
                    imem_addr_nxt = '0;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
            S_CLEAR: begin
                if (imem_addr == LAST_ADDR) begin
                    state_nxt = S_LOAD;
                end else begin
                    imem_addr_nxt = imem_addr + ADDR_W'(1);
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    // Out-of-range words are dropped but still flag the session.
                    if (in_range) begin
                        imem_wr_en_nxt = 1'b1;
                        imem_addr_nxt  = host_addr;
                        imem_wdata_nxt = host_data;
                        if (load_count != COUNT_MAX) begin
                            load_count_nxt = load_count + CNT_W'(1);
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                    if (host_last) begin
                        state_nxt    = S_HOLD;
                        hold_cnt_nxt = '0;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_END) begin
                    state_nxt = S_RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        case (state_nxt)
            S_IMRST: begin
                imem_reset_nxt = 1'b1;
                imem_rw_nxt    = 1'b0;
                busy_nxt       = 1'b1;
            end
            S_CLEAR: begin
                imem_rw_nxt    = 1'b0;
                imem_wr_en_nxt = 1'b1;
                imem_wdata_nxt = '0;
                busy_nxt       = 1'b1;
            end
            S_LOAD: begin
                imem_rw_nxt    = 1'b0;
                host_ready_nxt = 1'b1;
                busy_nxt       = 1'b1;
            end
            S_HOLD: begin
                // First HOLD cycle retires the final write, so memory stays in write mode.
                imem_rw_nxt = (hold_cnt_nxt != HOLD_W'(0));
                busy_nxt    = 1'b1;
            end
            S_RUN: begin
                core_reset_nxt = 1'b0;
                done_nxt       = 1'b1;
            end
            default: begin
                core_reset_nxt = 1'b1;
            end
        endcase
    end

endmodule
